// File: rtl/comparator_search.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comparator_search: binary search for a comparator's hidden operand,       |
// | one registered probe per clock. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
module comparator_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] probes
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MID0    = MAX_VAL >> 1;

  state_t           state_q;
  logic [WIDTH-1:0] lo_q, hi_q, guess_q, result_q, probes_q;
  logic             busy_q, done_q, found_q, err_q;

  // Candidate bounds and midpoints are kept one bit wider so sums never wrap.
  logic [WIDTH:0] lo_up_d, hi_dn_d, sum_up_d, sum_dn_d;
  logic           cross_up_d, cross_dn_d;

  always_comb begin
    lo_up_d    = {1'b0, guess_q} + 1'b1;
    hi_dn_d    = {1'b0, guess_q} - 1'b1;
    sum_up_d   = lo_up_d + {1'b0, hi_q};
    sum_dn_d   = {1'b0, lo_q} + hi_dn_d;
    cross_up_d = (lo_up_d > {1'b0, hi_q});
    cross_dn_d = ({1'b0, lo_q} > hi_dn_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            lo_q     <= '0;
            hi_q     <= MAX_VAL;
            guess_q  <= MID0;
            probes_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_PROBE;
          end
        end
        S_PROBE: begin
          probes_q <= probes_q + 1'b1;
          case ({eq, lt, gt})
            3'b100: begin
              result_q <= guess_q;
              found_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_DONE;
            end
            3'b010: begin
              if (guess_q == MAX_VAL || cross_up_d) begin
                result_q <= guess_q;
                err_q    <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= S_DONE;
              end else begin
                lo_q    <= lo_up_d[WIDTH-1:0];
                guess_q <= sum_up_d[WIDTH:1];
              end
            end
            3'b001: begin
              if (guess_q == '0 || cross_dn_d) begin
                result_q <= guess_q;
                err_q    <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= S_DONE;
              end else begin
                hi_q    <= hi_dn_d[WIDTH-1:0];
                guess_q <= sum_dn_d[WIDTH:1];
              end
            end
            default: begin
              result_q <= guess_q;
              err_q    <= 1'b1;
              found_q  <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign probes = probes_q;

endmodule
`default_nettype wire
